// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers the frame shown by a multiplexed 7-segment scan
// driver by sampling its SEG/AN lines and committing digits once they are stable.
module seg7_scan_decoder #(
  parameter int STABLE_CYC     = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  SEG,
  input  logic [7:0]  AN,
  output logic [63:0] frame,
  output logic [31:0] hex,
  output logic [7:0]  hex_ok,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic [15:0] frame_count,
  output logic        scan_err,
  output logic [1:0]  dbg_state
);

  // frame_valid, frame_changed and scan_err are single-cycle strobes with no
  // ready/backpressure: a consumer must sample them every clock.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  localparam logic [7:0] INACTIVE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] CAP_AT   = 8'(STABLE_CYC - 2);

  logic [7:0]  seg_s1, seg_s2, an_s1, an_s2;
  logic [7:0]  seg_n, an_n, seg_q, an_q;
  logic        an_blank, an_onehot, an_illegal, illegal_q, same;
  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic        capture, commit;
  logic [63:0] slots;
  logic [7:0]  mask;
  logic [4:0]  dec [8];

  // Synchronizers reset to the inactive pin level so reset reads as a blank scan.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      seg_s1 <= INACTIVE;
      seg_s2 <= INACTIVE;
      an_s1  <= INACTIVE;
      an_s2  <= INACTIVE;
    end else begin
      seg_s1 <= SEG;
      seg_s2 <= seg_s1;
      an_s1  <= AN;
      an_s2  <= an_s1;
    end
  end

  assign seg_n      = seg_s2 ^ INACTIVE;
  assign an_n       = an_s2 ^ INACTIVE;
  assign an_blank   = (an_n == 8'h00);
  assign an_onehot  = !an_blank && ((an_n & (an_n - 8'd1)) == 8'h00);
  assign an_illegal = !an_blank && !an_onehot;
  assign same       = (an_n == an_q) && (seg_n == seg_q);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      an_q      <= 8'h00;
      seg_q     <= 8'h00;
      illegal_q <= 1'b0;
      scan_err  <= 1'b0;
    end else begin
      an_q      <= an_n;
      seg_q     <= seg_n;
      illegal_q <= an_illegal;
      scan_err  <= an_illegal && !illegal_q;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= IDLE;
    else             state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (an_onehot) state_d = SETTLE;
      end
      SETTLE: begin
        if (!same)               state_d = an_onehot ? SETTLE : IDLE;
        else if (cnt == CAP_AT)  state_d = HELD;
      end
      HELD: begin
        if (!same) state_d = an_onehot ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The counter lands on STABLE_CYC-1 on the same edge the capture is written.
  always_comb begin
    capture = 1'b0;
    cnt_d   = 8'h00;
    case (state)
      SETTLE: begin
        if (same) begin
          cnt_d   = cnt + 8'd1;
          capture = (cnt == CAP_AT);
        end
      end
      HELD: begin
        if (same) cnt_d = cnt;
      end
      default: begin
        cnt_d   = 8'h00;
        capture = 1'b0;
      end
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) cnt <= 8'h00;
    else             cnt <= cnt_d;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      slots <= 64'h0;
    end else if (capture) begin
      for (int i = 0; i < 8; i++) begin
        if (an_n[i]) slots[i*8 +: 8] <= seg_n;
      end
    end
  end

  assign commit = (mask == 8'hFF);

  // A capture landing on the commit edge survives the mask clear.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      mask          <= 8'h00;
      frame         <= 64'h0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      frame_count   <= 16'h0000;
    end else begin
      mask          <= (commit ? 8'h00 : mask) | (capture ? an_n : 8'h00);
      frame_valid   <= commit;
      frame_changed <= commit && (slots != frame);
      if (commit) begin
        frame <= slots;
        if (slots != frame) frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Returns {match, nibble}; dp is not part of the glyph.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'h3F:   return 5'h10;
      7'h06:   return 5'h11;
      7'h5B:   return 5'h12;
      7'h4F:   return 5'h13;
      7'h66:   return 5'h14;
      7'h6D:   return 5'h15;
      7'h7D:   return 5'h16;
      7'h07:   return 5'h17;
      7'h7F:   return 5'h18;
      7'h6F:   return 5'h19;
      7'h77:   return 5'h1A;
      7'h7C:   return 5'h1B;
      7'h39:   return 5'h1C;
      7'h5E:   return 5'h1D;
      7'h79:   return 5'h1E;
      7'h71:   return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  for (genvar i = 0; i < 8; i++) begin : g_dec
    assign dec[i]         = decode_glyph(frame[i*8 +: 7]);
    assign hex[i*4 +: 4]  = dec[i][3:0];
    assign hex_ok[i]      = dec[i][4];
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: drives scan patterns at the pins and checks
// commits against a hold-length model of digit capture and frame assembly.
module tb_seg7_scan_decoder;

  localparam int S      = 16;
  localparam bit SEG_AL = 1'b1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_pin = 8'hFF;
  logic [7:0]  an_pin  = 8'hFF;
  logic [63:0] frame;
  logic [31:0] hex;
  logic [7:0]  hex_ok;
  logic        frame_valid, frame_changed, scan_err;
  logic [15:0] frame_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int fc_cnt = 0;
  int se_cnt = 0;
  int fv_last_cyc = 0;

  logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [7:0]  m_slot [8];
  logic [7:0]  m_mask;
  logic [63:0] m_frame;
  logic [15:0] m_count;
  logic [63:0] exp_q[$];
  logic        exp_chg_q[$];
  logic [63:0] mon_exp;
  logic        mon_chg;

  seg7_scan_decoder #(
    .STABLE_CYC     (S),
    .SEG_ACTIVE_LOW (SEG_AL)
  ) dut (
    .CLK100MHZ     (clk),
    .CPU_RESETN    (rst_n),
    .SEG           (seg_pin),
    .AN            (an_pin),
    .frame         (frame),
    .hex           (hex),
    .hex_ok        (hex_ok),
    .frame_valid   (frame_valid),
    .frame_changed (frame_changed),
    .frame_count   (frame_count),
    .scan_err      (scan_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        fv_cnt = fv_cnt + 1;
        fv_last_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_commit: got frame %h, required no commit", frame);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_chg = exp_chg_q.pop_front();
          if (frame !== mon_exp) begin
            errors++;
            $display("FAIL commit_frame: got %h required %h", frame, mon_exp);
          end
          checks++;
          if (frame_changed !== mon_chg) begin
            errors++;
            $display("FAIL commit_changed: got %b required %b", frame_changed, mon_chg);
          end
        end
      end
      if (frame_changed) fc_cnt = fc_cnt + 1;
      if (scan_err)      se_cnt = se_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] glyph(input int v);
    return {1'b0, glyph_tbl[v]};
  endfunction

  function automatic logic [7:0] rand_glyph();
    return {1'($urandom_range(0, 1)), glyph_tbl[$urandom_range(0, 15)]};
  endfunction

  // {hex_ok, hex} of a frame via table search.
  function automatic logic [39:0] model_hex(input logic [63:0] f);
    logic [39:0] r;
    r = 40'h0;
    for (int i = 0; i < 8; i++) begin
      for (int v = 0; v < 16; v++) begin
        if (f[i*8 +: 7] == glyph_tbl[v]) begin
          r[i*4 +: 4] = 4'(v);
          r[32 + i]   = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_slot[i] = 8'h00;
    m_mask  = 8'h00;
    m_frame = 64'h0;
    m_count = 16'h0;
    exp_q.delete();
    exp_chg_q.delete();
  endtask

  task automatic model_capture(input int idx, input logic [7:0] s);
    logic [63:0] f;
    m_slot[idx] = s;
    m_mask[idx] = 1'b1;
    if (m_mask == 8'hFF) begin
      for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_slot[i];
      exp_q.push_back(f);
      exp_chg_q.push_back(f != m_frame);
      if (f != m_frame) m_count = m_count + 16'd1;
      m_frame = f;
      m_mask  = 8'h00;
    end
  endtask

  // ---------------- drivers ----------------
  // Pins change #1 after a rising edge and hold for 'hold' edges.
  task automatic drive_pat(input logic [7:0] an_ah, input logic [7:0] seg_ah, input int hold);
    an_pin  = SEG_AL ? ~an_ah  : an_ah;
    seg_pin = SEG_AL ? ~seg_ah : seg_ah;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  // A digit is captured exactly when it is held for at least S cycles.
  task automatic drive_digit(input int idx, input logic [7:0] seg_ah, input int hold);
    if (hold >= S) model_capture(idx, seg_ah);
    drive_pat(8'(1 << idx), seg_ah, hold);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n   = 1'b0;
    an_pin  = SEG_AL ? 8'hFF : 8'h00;
    seg_pin = SEG_AL ? 8'hFF : 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (frame !== 64'h0) begin errors++; $display("FAIL reset_frame: got %h required 0", frame); end
    checks++; if (hex !== 32'h0) begin errors++; $display("FAIL reset_hex: got %h required 0", hex); end
    checks++; if (hex_ok !== 8'h00) begin errors++; $display("FAIL reset_hex_ok: got %h required 00", hex_ok); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b required 0", frame_valid); end
    checks++; if (frame_changed !== 1'b0) begin errors++; $display("FAIL reset_frame_changed: got %b required 0", frame_changed); end
    checks++; if (scan_err !== 1'b0) begin errors++; $display("FAIL reset_scan_err: got %b required 0", scan_err); end
    checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL reset_frame_count: got %h required 0", frame_count); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_pat(8'h00, 8'h00, 8);
    checks++; if (se_cnt !== 0) begin errors++; $display("FAIL post_reset_scan_err: got %0d pulses required 0", se_cnt); end
    checks++; if (fv_cnt !== 0) begin errors++; $display("FAIL post_reset_commit: got %0d commits required 0", fv_cnt); end
  endtask

  task automatic test_basic_scan();
    int fv0 = fv_cnt;
    int fc0 = fc_cnt;
    for (int i = 0; i < 8; i++) drive_digit(i, glyph(i), 64);
    drive_pat(8'h00, 8'h00, 6);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL basic_commits: got %0d required 1", fv_cnt - fv0); end
    checks++; if (fc_cnt - fc0 !== 1) begin errors++; $display("FAIL basic_changed: got %0d required 1", fc_cnt - fc0); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d required 1", frame_count); end
    checks++; if (hex !== 32'h76543210) begin errors++; $display("FAIL basic_hex: got %h required 76543210", hex); end
    checks++; if (hex_ok !== 8'hFF) begin errors++; $display("FAIL basic_hex_ok: got %h required ff", hex_ok); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_pending: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_repeat();
    int fv0 = fv_cnt;
    int fc0 = fc_cnt;
    for (int i = 0; i < 8; i++) drive_digit(i, glyph(i), 64);
    drive_pat(8'h00, 8'h00, 6);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL repeat_commits: got %0d required 1", fv_cnt - fv0); end
    checks++; if (fc_cnt - fc0 !== 0) begin errors++; $display("FAIL repeat_changed: got %0d required 0", fc_cnt - fc0); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL repeat_count: got %0d required 1", frame_count); end
  endtask

  task automatic test_short_hold();
    logic [7:0] g [8];
    int fv0 = fv_cnt;
    int t0 = 0;
    for (int i = 0; i < 8; i++) g[i] = rand_glyph();
    for (int i = 0; i < 8; i++) drive_digit(i, g[i], 10);
    for (int i = 0; i < 8; i++) drive_digit(i, g[i], S - 1);
    drive_pat(8'h00, 8'h00, 6);
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL short_commits: got %0d required 0", fv_cnt - fv0); end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) t0 = cyc;
      drive_digit(i, g[i], 18);
    end
    drive_pat(8'h00, 8'h00, 6);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL hold18_commits: got %0d required 1", fv_cnt - fv0); end
    checks++; if (fv_last_cyc - t0 !== S + 3) begin errors++; $display("FAIL hold18_latency: got %0d cycles required %0d", fv_last_cyc - t0, S + 3); end
    checks++; if (frame !== m_frame) begin errors++; $display("FAIL hold18_frame: got %h required %h", frame, m_frame); end
    checks++; if (frame_count !== m_count) begin errors++; $display("FAIL hold18_count: got %0d required %0d", frame_count, m_count); end
    for (int i = 0; i < 8; i++) g[i] = rand_glyph();
    for (int i = 0; i < 8; i++) drive_digit(i, g[i], S);
    drive_pat(8'h00, 8'h00, 6);
    checks++; if (fv_cnt - fv0 !== 2) begin errors++; $display("FAIL exact_hold_commits: got %0d required 2", fv_cnt - fv0); end
    checks++; if (frame !== m_frame) begin errors++; $display("FAIL exact_hold_frame: got %h required %h", frame, m_frame); end
  endtask

  task automatic test_scan_err();
    logic [7:0] bad_an = 8'b11110011;
    int se0 = se_cnt;
    int fv0 = fv_cnt;
    for (int i = 0; i < 4; i++) drive_digit(i, rand_glyph(), 20);
    drive_pat(SEG_AL ? ~bad_an : bad_an, rand_glyph(), 20);
    drive_pat(8'h00, 8'h00, 5);
    for (int i = 4; i < 8; i++) drive_digit(i, rand_glyph(), 20);
    drive_pat(8'h00, 8'h00, 6);
    checks++; if (se_cnt - se0 !== 1) begin errors++; $display("FAIL scan_err_pulses: got %0d required 1", se_cnt - se0); end
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL scan_err_commits: got %0d required 1", fv_cnt - fv0); end
    checks++; if (frame !== m_frame) begin errors++; $display("FAIL scan_err_frame: got %h required %h", frame, m_frame); end
    for (int i = 0; i < 8; i++) drive_digit(i, rand_glyph(), 24);
    drive_pat(8'h00, 8'h00, 6);
    checks++; if (fv_cnt - fv0 !== 2) begin errors++; $display("FAIL after_err_commits: got %0d required 2", fv_cnt - fv0); end
    checks++; if (frame !== m_frame) begin errors++; $display("FAIL after_err_frame: got %h required %h", frame, m_frame); end
    checks++; if (frame_count !== m_count) begin errors++; $display("FAIL after_err_count: got %0d required %0d", frame_count, m_count); end
    checks++; if (se_cnt - se0 !== 1) begin errors++; $display("FAIL after_err_pulses: got %0d required 1", se_cnt - se0); end
  endtask

  task automatic test_bad_glyph();
    logic [39:0] mh;
    for (int i = 0; i < 8; i++) drive_digit(i, (i == 3) ? 8'h49 : rand_glyph(), 20);
    drive_pat(8'h00, 8'h00, 6);
    mh = model_hex(m_frame);
    checks++; if (frame !== m_frame) begin errors++; $display("FAIL bad_glyph_frame: got %h required %h", frame, m_frame); end
    checks++; if (hex_ok !== 8'hF7) begin errors++; $display("FAIL bad_glyph_hex_ok: got %h required f7", hex_ok); end
    checks++; if (hex[15:12] !== 4'h0) begin errors++; $display("FAIL bad_glyph_nibble3: got %h required 0", hex[15:12]); end
    checks++; if (hex !== mh[31:0]) begin errors++; $display("FAIL bad_glyph_hex: got %h required %h", hex, mh[31:0]); end
  endtask

  task automatic test_reset_partial();
    int fv0;
    int fc0;
    for (int i = 0; i < 5; i++) drive_digit(i, rand_glyph(), 20);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (frame !== 64'h0) begin errors++; $display("FAIL async_reset_frame: got %h required 0", frame); end
    checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL async_reset_count: got %0d required 0", frame_count); end
    checks++; if (hex_ok !== 8'h00) begin errors++; $display("FAIL async_reset_hex_ok: got %h required 00", hex_ok); end
    model_reset();
    an_pin  = SEG_AL ? 8'hFF : 8'h00;
    seg_pin = SEG_AL ? 8'hFF : 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    fv0 = fv_cnt;
    fc0 = fc_cnt;
    for (int i = 0; i < 8; i++) drive_digit(i, rand_glyph(), 20);
    drive_pat(8'h00, 8'h00, 6);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL partial_commits: got %0d required 1", fv_cnt - fv0); end
    checks++; if (fc_cnt - fc0 !== 1) begin errors++; $display("FAIL partial_changed: got %0d required 1", fc_cnt - fc0); end
    checks++; if (frame !== m_frame) begin errors++; $display("FAIL partial_frame: got %h required %h", frame, m_frame); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL partial_count: got %0d required 1", frame_count); end
  endtask

  task automatic test_random();
    logic [39:0] mh;
    int prev = 8;
    int idx;
    for (int n = 0; n < 150; n++) begin
      if (prev != 8 && $urandom_range(0, 7) == 0) begin
        drive_pat(8'h00, 8'h00, $urandom_range(1, 20));
        prev = 8;
      end else begin
        do idx = $urandom_range(0, 7); while (idx == prev);
        drive_digit(idx, ($urandom_range(0, 1) == 1) ? rand_glyph() : 8'($urandom_range(0, 255)),
                    $urandom_range(S - 3, S + 10));
        prev = idx;
      end
    end
    drive_pat(8'h00, 8'h00, 8);
    mh = model_hex(m_frame);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL random_pending: got %0d pending required 0", exp_q.size()); end
    checks++; if (frame !== m_frame) begin errors++; $display("FAIL random_frame: got %h required %h", frame, m_frame); end
    checks++; if (frame_count !== m_count) begin errors++; $display("FAIL random_count: got %0d required %0d", frame_count, m_count); end
    checks++; if (hex !== mh[31:0]) begin errors++; $display("FAIL random_hex: got %h required %h", hex, mh[31:0]); end
    checks++; if (hex_ok !== mh[39:32]) begin errors++; $display("FAIL random_hex_ok: got %h required %h", hex_ok, mh[39:32]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_scan();
    test_repeat();
    test_short_hold();
    test_scan_err();
    test_bad_glyph();
    test_reset_partial();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
